// File: rtl/data_mem_ctrl.sv
// Data-memory stage behind the core's MEM step: a word-organised RAM with
// configurable wait states, access checking and a one-cycle ready pulse.
module data_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] RANGE_BYTES = 32'(DEPTH * 4);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_CONFLICT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t             state_q;
    logic               armed_q;
    logic [3:0]         cnt_q;
    logic               write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               busy_q;
    logic               err_q;
    logic [1:0]         err_code_q;

    logic [31:0]        mem [DEPTH];

    logic               req_d;
    logic               accept_d;
    logic [31:0]        offset_d;
    logic [1:0]         err_code_d;

    assign req_d    = MemRead | MemWrite;
    assign accept_d = (state_q == S_IDLE) && armed_q && req_d;
    // Addresses below the base wrap to large offsets and fail the range check.
    assign offset_d = dAddress - BASE_ADDR;

    always_comb begin
        err_code_d = ERR_NONE;
        if (MemRead && MemWrite)
            err_code_d = ERR_CONFLICT;
        else if (dAddress[1:0] != 2'b00)
            err_code_d = ERR_MISALIGN;
        else if (offset_d >= RANGE_BYTES)
            err_code_d = ERR_RANGE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b1;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            // A request held across completion must drop before it can re-arm.
            if (!req_d)
                armed_q <= 1'b1;
            else if (accept_d)
                armed_q <= 1'b0;

            ready_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        write_q    <= MemWrite;
                        idx_q      <= offset_d[IDX_W+1:2];
                        wdata_q    <= dWriteData;
                        err_q      <= (err_code_d != ERR_NONE);
                        err_code_q <= err_code_d;
                        busy_q     <= 1'b1;
                        if (err_code_d != ERR_NONE) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q <= S_ACCESS;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!write_q)
                        rdata_q <= mem[idx_q];
                    state_q <= S_DONE;
                    ready_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; clearing it would forbid block-RAM
    // inference, and its contents are defined only by prior writes.
    always_ff @(posedge clk) begin
        if (rst && state_q == S_ACCESS && write_q)
            mem[idx_q] <= wdata_q;
    end

    assign dReadData = rdata_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
